// File: rtl/mesi_main_memory_if.sv
// Request/response bus between a requester and mesi_main_memory.
// Ports: req_* (valid/ready request carrying op, page, addr, wdata, mesi),
//        rsp_* (valid/ready response carrying rdata, mesi).
interface mesi_main_memory_if #(
  parameter int PAGE_W = 1,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [PAGE_W-1:0] req_page;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_mesi;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_mesi;

  modport master (
    output req_valid, req_op, req_page, req_addr, req_wdata, req_mesi, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_mesi
  );

  modport slave (
    input  req_valid, req_op, req_page, req_addr, req_wdata, req_mesi, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_mesi
  );
endinterface

// File: rtl/mesi_main_memory.sv
// Main memory holding a data word plus MESI state per line, indexed by {page, addr}.
// Ports: clk, reset (sync, active-high), bus (slave side of mesi_main_memory_if), init_done.
// One request at a time; response valid LATENCY edges after accept; held until rsp_ready.
// MESI encoding: 00 INVALID, 01 SHARED, 10 EXCLUSIVE, 11 MODIFIED.
// Ops: 00 READ, 01 WRITE (data+mesi), 10 SET_MESI (state only), 11 READ.
module mesi_main_memory #(
  parameter int PAGE_W  = 1,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mesi_main_memory_if.slave    bus,
  output logic                 init_done
);
  localparam int IDX_W = PAGE_W + ADDR_W;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] MESI_INVALID = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_MESI  = 2'b10;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   init_idx;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         op;
  logic [DATA_W-1:0]  wdata;
  logic [1:0]         mesi;
  logic [3:0]         cnt;
  logic               req_ready;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata;
  logic [1:0]         rsp_mesi;

  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [1:0]         mesi_mem [DEPTH];

  // Shared write port for the init sweep and the commit at the end of BUSY.
  logic               we_data;
  logic               we_mesi;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_data;
  logic [1:0]         w_mesi;

  logic               is_write;
  logic               is_set;

  assign is_write = (op == OP_WRITE);
  assign is_set   = (op == OP_SET_MESI);

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_mesi  = rsp_mesi;

  // Writes are gated by reset so an uncommitted write is dropped when reset lands in BUSY.
  always_comb begin
    we_data = 1'b0;
    we_mesi = 1'b0;
    w_idx   = idx;
    w_data  = wdata;
    w_mesi  = mesi;
    if (!reset) begin
      case (state)
        S_INIT: begin
          we_data = 1'b1;
          we_mesi = 1'b1;
          w_idx   = init_idx;
          w_data  = '0;
          w_mesi  = MESI_INVALID;
        end
        S_BUSY: begin
          if (cnt == 4'd0) begin
            we_data = is_write;
            we_mesi = is_write | is_set;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we_data) data_mem[w_idx] <= w_data;
    if (we_mesi) mesi_mem[w_idx] <= w_mesi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      init_idx  <= '0;
      idx       <= '0;
      op        <= '0;
      wdata     <= '0;
      mesi      <= MESI_INVALID;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_mesi  <= MESI_INVALID;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == {IDX_W{1'b1}}) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.req_valid) begin
            op        <= bus.req_op;
            idx       <= {bus.req_page, bus.req_addr};
            wdata     <= bus.req_wdata;
            mesi      <= bus.req_mesi;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) begin
            // Response reflects the line after the commit happening on this same edge.
            rsp_rdata <= is_write ? wdata : data_mem[idx];
            rsp_mesi  <= (is_write | is_set) ? mesi : mesi_mem[idx];
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mesi_main_memory.sv
// Drives two memories (LATENCY 1 and 4) with the same request stream and checks
// both against a line-array model of the memory contents.
module tb_mesi_main_memory;
  localparam int PAGE_W = 1;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << (PAGE_W + ADDR_W);
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 4;

  localparam logic [1:0] M_I = 2'd0, M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;
  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_SET = 2'b10, OP_RD3 = 2'b11;

  logic clk;
  logic reset;
  logic              req_valid;
  logic [1:0]        req_op;
  logic [PAGE_W-1:0] req_page;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_mesi;
  logic [1:0]        rsp_ready;

  logic [1:0]        rv, rr, id;
  logic [DATA_W-1:0] rd [2];
  logic [1:0]        rm [2];
  logic              id_a, id_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mesi_main_memory_if #(.PAGE_W(PAGE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_a ();
  mesi_main_memory_if #(.PAGE_W(PAGE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_b ();

  assign if_a.req_valid = req_valid;  assign if_b.req_valid = req_valid;
  assign if_a.req_op    = req_op;     assign if_b.req_op    = req_op;
  assign if_a.req_page  = req_page;   assign if_b.req_page  = req_page;
  assign if_a.req_addr  = req_addr;   assign if_b.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;  assign if_b.req_wdata = req_wdata;
  assign if_a.req_mesi  = req_mesi;   assign if_b.req_mesi  = req_mesi;
  assign if_a.rsp_ready = rsp_ready[0];
  assign if_b.rsp_ready = rsp_ready[1];

  assign rv = {if_b.rsp_valid, if_a.rsp_valid};
  assign rr = {if_b.req_ready, if_a.req_ready};
  assign id = {id_b, id_a};
  assign rd[0] = if_a.rsp_rdata;  assign rd[1] = if_b.rsp_rdata;
  assign rm[0] = if_a.rsp_mesi;   assign rm[1] = if_b.rsp_mesi;

  mesi_main_memory #(.PAGE_W(PAGE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .init_done(id_a));
  mesi_main_memory #(.PAGE_W(PAGE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .init_done(id_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Model: contents of every line, plus the response expected for the request in flight.
  logic [DATA_W-1:0] m_data [DEPTH];
  logic [1:0]        m_mesi [DEPTH];
  logic [DATA_W-1:0] exp_rd;
  logic [1:0]        exp_rm;
  int                acc_cyc;
  logic [1:0]        outst = 2'b00;
  logic [1:0]        prev_rv = 2'b00;
  logic [DATA_W-1:0] last_rd [2];
  logic [1:0]        last_rm [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0;
      m_mesi[i] = M_I;
    end
  endtask

  // Compare process: every response cycle is checked against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          chk("req_ready_low_in_resp", 64'(rr[k]), 64'd0);
          if (!prev_rv[k]) begin
            chk("rsp_requested", 64'(outst[k]), 64'd1);
            chk("rsp_latency", 64'(cyc - acc_cyc), 64'((k == 0) ? LAT_A : LAT_B));
            chk("rsp_rdata", 64'(rd[k]), 64'(exp_rd));
            chk("rsp_mesi", 64'(rm[k]), 64'(exp_rm));
            last_rd[k] = rd[k];
            last_rm[k] = rm[k];
          end else begin
            chk("rdata_stable", 64'(rd[k]), 64'(last_rd[k]));
            chk("mesi_stable", 64'(rm[k]), 64'(last_rm[k]));
          end
        end
      end
    end
    prev_rv = rv;
  end

  // Presents a request until both memories accept it and updates the model.
  task automatic issue(input logic [1:0] op, input logic [PAGE_W-1:0] pg,
                       input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd,
                       input logic [1:0] ms);
    int n;
    int ix;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_page  = pg;
    req_addr  = ad;
    req_wdata = wd;
    req_mesi  = ms;
    n = 0;
    while (rr != 2'b11 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(rr), 64'd3);
    acc_cyc = cyc + 1;
    ix = int'({pg, ad});
    case (op)
      OP_WR: begin m_data[ix] = wd; m_mesi[ix] = ms; end
      OP_SET: m_mesi[ix] = ms;
      default: ;
    endcase
    exp_rd = m_data[ix];
    exp_rm = m_mesi[ix];
    outst  = 2'b11;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for both responses, holding rsp_ready low for 'hold' response cycles.
  task automatic finish_rsp(input int hold, input bit pulse);
    logic [1:0] done;
    int seen [2];
    int it;
    done = 2'b00;
    seen[0] = 0;
    seen[1] = 0;
    it = 0;
    while (done != 2'b11 && it < 60) begin
      @(negedge clk);
      it++;
      if (pulse && it == 5) begin req_valid = 1'b1; req_op = OP_RD3; end
      if (pulse && it == 6) req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          if (rsp_ready[k]) begin
            rsp_ready[k] = 1'b0;
            done[k] = 1'b1;
            outst[k] = 1'b0;
          end else if (rv[k]) begin
            if (seen[k] >= hold) rsp_ready[k] = 1'b1;
            else seen[k]++;
          end
        end
      end
    end
    if (done != 2'b11) chk("rsp_timeout", 64'(done), 64'd3);
  endtask

  task automatic pin(input string nm, input logic [DATA_W-1:0] d, input logic [1:0] m);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_data"}, 64'(last_rd[k]), 64'(d));
      chk({nm, "_mesi"}, 64'(last_rm[k]), 64'(m));
    end
  endtask

  task automatic wait_init();
    repeat (DEPTH - 1) @(negedge clk);
    chk("init_done_before", 64'(id), 64'd0);
    @(negedge clk);
    chk("init_done_after", 64'(id), 64'd3);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = '0; req_page = '0; req_addr = '0; req_wdata = '0; req_mesi = '0;
    rsp_ready = 2'b00;
    model_clear();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 64'(rr[k]), 64'd0);
      chk("rst_rsp_valid", 64'(rv[k]), 64'd0);
      chk("rst_rsp_rdata", 64'(rd[k]), 64'd0);
      chk("rst_rsp_mesi", 64'(rm[k]), 64'(M_I));
      chk("rst_init_done", 64'(id[k]), 64'd0);
    end
    reset = 1'b0;
    wait_init();

    // Fresh memory reads as zero/INVALID at the top of page 1.
    issue(OP_RD, 1'b1, 8'hFF, '0, '0);  finish_rsp(0, 0);  pin("t1_rd", 32'h0, M_I);

    // WRITE then READ back.
    issue(OP_WR, 1'b1, 8'h3C, 32'hA5A50001, M_M);  finish_rsp(0, 0);  pin("t2_wr", 32'hA5A50001, M_M);
    issue(OP_RD, 1'b1, 8'h3C, '0, '0);  finish_rsp(0, 0);  pin("t2_rd", 32'hA5A50001, M_M);

    // State-only update keeps the data.
    issue(OP_SET, 1'b1, 8'h3C, 32'hFFFFFFFF, M_S);  finish_rsp(0, 0);  pin("t3_set", 32'hA5A50001, M_S);
    issue(OP_RD, 1'b1, 8'h3C, '0, '0);  finish_rsp(0, 0);  pin("t3_rd", 32'hA5A50001, M_S);

    // Op 11 read with rsp_ready held low and a stray request pulse during RESP.
    issue(OP_RD3, 1'b1, 8'h3C, '0, '0);  finish_rsp(5, 1);  pin("t4_rd", 32'hA5A50001, M_S);

    // Lowest and highest index are distinct lines.
    issue(OP_WR, 1'b0, 8'h00, 32'h11111111, M_E);  finish_rsp(0, 0);
    issue(OP_WR, 1'b1, 8'hFF, 32'h22222222, M_M);  finish_rsp(0, 0);
    issue(OP_RD, 1'b0, 8'h00, '0, '0);  finish_rsp(0, 0);  pin("t5_rd0", 32'h11111111, M_E);
    issue(OP_RD, 1'b1, 8'hFF, '0, '0);  finish_rsp(0, 0);  pin("t5_rdmax", 32'h22222222, M_M);

    // Reset while a WRITE is in BUSY: write dropped, memory swept again.
    issue(OP_WR, 1'b0, 8'h77, 32'hDEADBEEF, M_M);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("t6_rsp_valid_after_rst", 64'(rv[k]), 64'd0);
      chk("t6_req_ready_after_rst", 64'(rr[k]), 64'd0);
      chk("t6_init_done_after_rst", 64'(id[k]), 64'd0);
    end
    outst = 2'b00;
    model_clear();
    reset = 1'b0;
    wait_init();
    issue(OP_RD, 1'b0, 8'h77, '0, '0);  finish_rsp(0, 0);  pin("t6_rd_dropped", 32'h0, M_I);
    issue(OP_RD, 1'b1, 8'h3C, '0, '0);  finish_rsp(0, 0);  pin("t6_rd_cleared", 32'h0, M_I);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
